// File: rtl/counter_event_monitor_pkg.sv
// Shared definitions for the counter event monitor: event mask bit positions,
// the sampling FSM states and the event-record packing helper.
package counter_mon_pkg;

    localparam int MASK_WRAP1 = 0;
    localparam int MASK_WRAP2 = 1;
    localparam int MASK_MATCH = 2;

    // Widest record the packing helper can build; callers truncate to their width.
    localparam int REC_MAX_W = 64;

    typedef enum logic {
        PRIME,
        TRACK
    } mon_state_e;

    // Packs {ts, mask, c1, c2} with c1/c2 each cnt_w bits wide. Inputs are
    // expected zero-extended; the caller casts the result to its record width.
    function automatic logic [REC_MAX_W-1:0] pack_record(
        input int                   cnt_w,
        input logic [REC_MAX_W-1:0] ts,
        input logic [2:0]           mask,
        input logic [REC_MAX_W-1:0] c1,
        input logic [REC_MAX_W-1:0] c2
    );
        logic [REC_MAX_W-1:0] rec;
        rec = (ts << (3 + 2 * cnt_w))
            | ({{(REC_MAX_W-3){1'b0}}, mask} << (2 * cnt_w))
            | (c1 << cnt_w)
            | c2;
        return rec;
    endfunction

endpackage

// File: rtl/counter_event_monitor_if.sv
// Valid/ready event stream carrying packed event records out of the monitor.
interface counter_event_monitor_if #(
    parameter int W = 27
) ();
    logic         evt_valid;
    logic         evt_ready;
    logic [W-1:0] evt_data;

    modport master (output evt_valid, output evt_data, input evt_ready);
    modport slave  (input evt_valid, input evt_data, output evt_ready);
endinterface

// File: rtl/counter_event_monitor_sync_fifo.sv
// Synchronous FIFO with a registered head output. A push into an empty FIFO
// becomes visible on dout one cycle later; a push while full is accepted only
// when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 27,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_nxt;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_nxt  = rd_ptr + 1'b1;

    // Storage array write; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and registered head entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_nxt;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Head refresh: next stored entry on pop, or the incoming word
            // when it becomes the only entry.
            if (do_pop) begin
                if (count > (AW+1)'(1)) begin
                    dout <= mem[rd_nxt];
                end else if (do_push) begin
                    dout <= din;
                end
            end else if (empty && do_push) begin
                dout <= din;
            end
        end
    end

endmodule

// File: rtl/counter_event_monitor.sv
// Samples two upstream counters, detects wrap-around and equality rising
// edges, queues timestamped event records and keeps saturating statistics.
module counter_event_monitor
    import counter_mon_pkg::*;
#(
    parameter int CNT_W      = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int TS_W       = 16,
    parameter int STAT_W     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      clr_stats,
    input  logic [CNT_W-1:0]          counter1,
    input  logic [CNT_W-1:0]          counter2,
    counter_event_monitor_if.master   evt,
    output logic [STAT_W-1:0]         wrap_cnt1,
    output logic [STAT_W-1:0]         wrap_cnt2,
    output logic [STAT_W-1:0]         drop_cnt,
    output logic                      overflow
);
    localparam int REC_W = TS_W + 3 + 2 * CNT_W;

    mon_state_e       state;
    logic [TS_W-1:0]  ts;
    logic [CNT_W-1:0] prev1;
    logic [CNT_W-1:0] prev2;
    logic             prev_eq;
    logic [2:0]       mask;
    logic [REC_W-1:0] rec;
    logic             push;
    logic             pop;
    logic             drop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [REC_W-1:0] fifo_dout;

    function automatic logic [STAT_W-1:0] sat_inc(
        input logic [STAT_W-1:0] v,
        input logic              inc
    );
        if (inc && (v != {STAT_W{1'b1}})) begin
            return v + 1'b1;
        end
        return v;
    endfunction

    // Event detection against the previous enabled sample (TRACK only).
    always_comb begin
        mask = '0;
        if (en && (state == TRACK)) begin
            mask[MASK_WRAP1] = (counter1 < prev1);
            mask[MASK_WRAP2] = (counter2 < prev2);
            mask[MASK_MATCH] = (counter1 == counter2) && !prev_eq;
        end
    end

    assign push = |mask;
    assign pop  = !fifo_empty && evt.evt_ready;
    assign drop = push && fifo_full && !pop;
    assign rec  = REC_W'(pack_record(CNT_W, REC_MAX_W'(ts), mask,
                                     REC_MAX_W'(counter1), REC_MAX_W'(counter2)));

    assign evt.evt_valid = !fifo_empty;
    assign evt.evt_data  = fifo_dout;

    // Free-running timestamp, independent of en.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts <= '0;
        end else begin
            ts <= ts + 1'b1;
        end
    end

    // Sampling FSM: first enabled sample only primes the history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= PRIME;
            prev1   <= '0;
            prev2   <= '0;
            prev_eq <= 1'b0;
        end else if (en) begin
            case (state)
                PRIME:   state <= TRACK;
                TRACK:   state <= TRACK;
                default: state <= PRIME;
            endcase
            prev1   <= counter1;
            prev2   <= counter2;
            prev_eq <= (counter1 == counter2);
        end
    end

    // Saturating statistics; a clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            wrap_cnt1 <= '0;
            wrap_cnt2 <= '0;
            drop_cnt  <= '0;
            overflow  <= 1'b0;
        end else begin
            wrap_cnt1 <= sat_inc(wrap_cnt1, mask[MASK_WRAP1]);
            wrap_cnt2 <= sat_inc(wrap_cnt2, mask[MASK_WRAP2]);
            drop_cnt  <= sat_inc(drop_cnt, drop);
            overflow  <= overflow | drop;
        end
    end

    sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (rec),
        .full  (fifo_full),
        .pop   (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_counter_event_monitor.sv
// Bench for counter_event_monitor: directed scenarios followed by random
// traffic, every cycle compared against a queue-based reference model.
module tb_counter_event_monitor;
    localparam int CNT_W      = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int TS_W       = 16;
    localparam int STAT_W     = 8;
    localparam int REC_W      = TS_W + 3 + 2 * CNT_W;
    localparam int STAT_MAX   = (1 << STAT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              clr_stats;
    logic [CNT_W-1:0]  counter1;
    logic [CNT_W-1:0]  counter2;
    logic [STAT_W-1:0] wrap_cnt1;
    logic [STAT_W-1:0] wrap_cnt2;
    logic [STAT_W-1:0] drop_cnt;
    logic              overflow;

    counter_event_monitor_if #(.W(REC_W)) evt_if ();

    counter_event_monitor #(
        .CNT_W      (CNT_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .TS_W       (TS_W),
        .STAT_W     (STAT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clr_stats (clr_stats),
        .counter1  (counter1),
        .counter2  (counter2),
        .evt       (evt_if),
        .wrap_cnt1 (wrap_cnt1),
        .wrap_cnt2 (wrap_cnt2),
        .drop_cnt  (drop_cnt),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    int               m_ts;
    bit               m_primed;
    int               m_p1;
    int               m_p2;
    bit               m_peq;
    logic [REC_W-1:0] m_q[$];
    int               m_w1;
    int               m_w2;
    int               m_drop;
    bit               m_ovf;

    function automatic int sat(input int v);
        return (v < STAT_MAX) ? v + 1 : STAT_MAX;
    endfunction

    task automatic model_step();
        bit   pop;
        bit   w1;
        bit   w2;
        bit   mt;
        bit   dropped;
        logic [TS_W-1:0] tsv;
        if (rst) begin
            m_q.delete();
            m_ts = 0; m_primed = 0; m_p1 = 0; m_p2 = 0; m_peq = 0;
            m_w1 = 0; m_w2 = 0; m_drop = 0; m_ovf = 0;
        end else begin
            pop = (m_q.size() > 0) && evt_if.evt_ready;
            w1 = 0; w2 = 0; mt = 0; dropped = 0;
            if (en) begin
                if (m_primed) begin
                    w1 = (int'(counter1) < m_p1);
                    w2 = (int'(counter2) < m_p2);
                    mt = (counter1 == counter2) && !m_peq;
                end
                m_primed = 1;
                m_p1 = int'(counter1);
                m_p2 = int'(counter2);
                m_peq = (counter1 == counter2);
            end
            if (pop) void'(m_q.pop_front());
            if (w1 || w2 || mt) begin
                tsv = m_ts[TS_W-1:0];
                if (m_q.size() < FIFO_DEPTH)
                    m_q.push_back({tsv, mt, w2, w1, counter1, counter2});
                else
                    dropped = 1;
            end
            if (clr_stats) begin
                m_w1 = 0; m_w2 = 0; m_drop = 0; m_ovf = 0;
            end else begin
                if (w1) m_w1 = sat(m_w1);
                if (w2) m_w2 = sat(m_w2);
                if (dropped) begin
                    m_drop = sat(m_drop);
                    m_ovf = 1;
                end
            end
            m_ts = (m_ts + 1) % (1 << TS_W);
        end
    endtask

    task automatic check_all();
        chk("evt_valid", evt_if.evt_valid, (m_q.size() > 0));
        if (m_q.size() > 0) chk("evt_data", evt_if.evt_data, m_q[0]);
        chk("wrap_cnt1", wrap_cnt1, m_w1);
        chk("wrap_cnt2", wrap_cnt2, m_w2);
        chk("drop_cnt", drop_cnt, m_drop);
        chk("overflow", overflow, m_ovf);
    endtask

    task automatic cyc(input bit r, input bit e, input bit cl, input int c1, input int c2, input bit rdy);
        rst = r; en = e; clr_stats = cl;
        counter1 = c1[CNT_W-1:0];
        counter2 = c2[CNT_W-1:0];
        evt_if.evt_ready = rdy;
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    function automatic logic [2:0] head_mask();
        return evt_if.evt_data[2*CNT_W +: 3];
    endfunction

    function automatic logic [TS_W-1:0] head_ts();
        return evt_if.evt_data[REC_W-1 -: TS_W];
    endfunction

    logic [TS_W-1:0] cur_ts;
    logic [TS_W-1:0] last_ts;
    int              rc1;
    int              rc2;

    initial begin
        rst = 1'b1; en = 1'b0; clr_stats = 1'b0;
        counter1 = '0; counter2 = '0; evt_if.evt_ready = 1'b0;

        // Reset then first enabled cycle primes only
        repeat (3) cyc(1, 1, 0, 0, 0, 0);
        chk("s1_rst_valid", evt_if.evt_valid, 0);
        chk("s1_rst_stats", {wrap_cnt1, wrap_cnt2, drop_cnt, overflow}, 0);
        cyc(0, 1, 0, 0, 0, 1);
        chk("s1_no_push", evt_if.evt_valid, 0);

        // Counter1 wraps 15 -> 0
        cyc(1, 0, 0, 0, 0, 1);
        cyc(0, 1, 0, 14, 5, 1);
        cyc(0, 1, 0, 15, 5, 1);
        cyc(0, 1, 0, 0, 5, 1);
        chk("s2_valid", evt_if.evt_valid, 1);
        chk("s2_mask", head_mask(), 3'b001);
        chk("s2_c1", evt_if.evt_data[CNT_W +: CNT_W], 0);
        chk("s2_ts", head_ts(), 2);
        chk("s2_wrap1", wrap_cnt1, 1);
        cyc(0, 0, 0, 0, 5, 1);
        chk("s2_drained", evt_if.evt_valid, 0);

        // Held equality fires one MATCH
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 3, 2, 0);
        repeat (4) cyc(0, 1, 0, 3, 3, 0);
        chk("s3_valid", evt_if.evt_valid, 1);
        chk("s3_mask", head_mask(), 3'b100);
        cyc(0, 0, 0, 3, 3, 1);
        chk("s3_single", evt_if.evt_valid, 0);

        // Overflow: 10 wraps of counter2 with consumer stalled
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 7, 15, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, 0, 7, 0, 0);
            cyc(0, 1, 0, 7, 15, 0);
        end
        chk("s4_drop", drop_cnt, 2);
        chk("s4_ovf", overflow, 1);
        chk("s4_wrap2", wrap_cnt2, 10);
        last_ts = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            cur_ts = head_ts();
            chk("s4_pop_valid", evt_if.evt_valid, 1);
            if (i > 0) chk("s4_ts_order", (cur_ts > last_ts), 1);
            last_ts = cur_ts;
            cyc(0, 0, 0, 7, 15, 1);
        end
        chk("s4_empty", evt_if.evt_valid, 0);

        // Both counters wrap into equality in the same sample
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 15, 14, 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("s5_mask", head_mask(), 3'b111);

        // Reset with records queued
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 15, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0, 1, 0);
            cyc(0, 1, 0, 15, 1, 0);
        end
        chk("s6_queued", evt_if.evt_valid, 1);
        cyc(1, 0, 0, 15, 1, 0);
        chk("s6_flushed", evt_if.evt_valid, 0);
        cyc(0, 1, 0, 15, 1, 0);
        chk("s6_prime", evt_if.evt_valid, 0);
        cyc(0, 1, 0, 0, 1, 0);
        chk("s6_ts_restart", head_ts(), 1);

        // Random traffic
        rc1 = 0; rc2 = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1) == 0) rc1 = (rc1 + 1) % 16;
            else rc1 = int'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) rc2 = int'($urandom_range(0, 15));
            else rc2 = (rc2 + 1) % 16;
            cyc(($urandom_range(0, 299) == 0),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 99) == 0),
                rc1, rc2,
                ($urandom_range(0, 2) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
